acc_exec_unit: RTL

ACC_EXEC_UNIT -- requirements
Module: acc_exec_unit

---
 rtl/acc_exec_unit_pkg.sv | 32 +++
 rtl/acc_exec_unit_dec.sv | 25 ++
 rtl/acc_exec_unit.sv | 133 +++++++++++++
 3 files changed

// File: rtl/acc_exec_unit_pkg.sv
// Shared encodings for the accumulator execution unit: opcodes, FSM states
// and the ALU strobe bundle.
package acc_exec_unit_pkg;

  typedef enum logic [2:0] {
    OP_NOP = 3'b000,
    OP_ADD = 3'b001,
    OP_SUB = 3'b010,
    OP_CMP = 3'b011,
    OP_AND = 3'b100,
    OP_OR  = 3'b101,
    OP_XOR = 3'b110,
    OP_LDA = 3'b111
  } opcode_t;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DRIVE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_RETIRE  = 2'd3
  } state_t;

  typedef struct packed {
    logic add;
    logic sub;
    logic comp;
    logic andd;
    logic orr;
    logic xorr;
  } strobe_t;

endpackage

// File: rtl/acc_exec_unit_dec.sv
// Opcode to one-hot ALU strobe decoder; all strobes stay low unless enabled.
module acc_exec_unit_dec
  import acc_exec_unit_pkg::*;
(
  input  logic    en,
  input  opcode_t op,
  output strobe_t strb
);

  always_comb begin
    strb = '0;
    if (en) begin
      case (op)
        OP_ADD:  strb.add  = 1'b1;
        OP_SUB:  strb.sub  = 1'b1;
        OP_CMP:  strb.comp = 1'b1;
        OP_AND:  strb.andd = 1'b1;
        OP_OR:   strb.orr  = 1'b1;
        OP_XOR:  strb.xorr = 1'b1;
        default: strb      = '0;
      endcase
    end
  end

endmodule

// File: rtl/acc_exec_unit.sv
// Accumulator execution unit: sequences one instruction through an external
// ALU in four cycles and retires the result into acc and the zf/cf flags.
//
// state   | meaning
// IDLE    | op_ready high, waiting for op_valid
// DRIVE   | bus holds operand, one ALU strobe asserted
// CAPTURE | strobes low, ALU result settles on z; acc/flags load at exit
// RETIRE  | done pulse, back to IDLE next edge
module acc_exec_unit
  import acc_exec_unit_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       op_valid,
  output logic       op_ready,
  input  logic [2:0] opcode,
  input  logic [7:0] operand,
  output logic [7:0] bus,
  output logic [7:0] acc,
  output logic       add,
  output logic       sub,
  output logic       comp,
  output logic       andd,
  output logic       orr,
  output logic       xorr,
  input  logic [7:0] z,
  output logic       done,
  output logic       zf,
  output logic       cf
);

  state_t  state, state_nxt;
  opcode_t op_q;
  strobe_t strb;
  logic    accept;
  logic    carry, borrow;
  logic [7:0] diff, res;
  logic    load_acc, upd_flags, cf_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    op_ready  = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        op_ready = 1'b1;
        if (op_valid) state_nxt = S_DRIVE;
      end
      S_DRIVE:   state_nxt = S_CAPTURE;
      S_CAPTURE: state_nxt = S_RETIRE;
      S_RETIRE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default:   state_nxt = S_IDLE;
    endcase
  end

  assign accept = op_valid & op_ready;

  acc_exec_unit_dec u_dec (
    .en   (state == S_DRIVE),
    .op   (op_q),
    .strb (strb)
  );

  assign add  = strb.add;
  assign sub  = strb.sub;
  assign comp = strb.comp;
  assign andd = strb.andd;
  assign orr  = strb.orr;
  assign xorr = strb.xorr;

  // bus holds the latched operand, so it doubles as the local copy for CMP/carry
  assign carry  = (9'(acc) + 9'(bus)) > 9'd255;
  assign borrow = acc < bus;
  assign diff   = acc - bus;

  always_comb begin
    res       = z;
    load_acc  = 1'b0;
    upd_flags = 1'b1;
    cf_nxt    = 1'b0;
    case (op_q)
      OP_ADD: begin
        load_acc = 1'b1;
        cf_nxt   = carry;
      end
      OP_SUB: begin
        load_acc = 1'b1;
        cf_nxt   = borrow;
      end
      OP_CMP: begin
        res    = diff;
        cf_nxt = borrow;
      end
      OP_AND, OP_OR, OP_XOR: load_acc = 1'b1;
      OP_LDA: begin
        res      = bus;
        load_acc = 1'b1;
      end
      default: upd_flags = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q <= OP_NOP;
      bus  <= 8'h00;
      acc  <= 8'h00;
      zf   <= 1'b0;
      cf   <= 1'b0;
    end else begin
      if (accept) begin
        op_q <= opcode_t'(opcode);
        bus  <= operand;
      end
      if (state == S_CAPTURE) begin
        if (load_acc) acc <= res;
        if (upd_flags) begin
          zf <= (res == 8'h00);
          cf <= cf_nxt;
        end
      end
    end
  end

endmodule
